// File: rtl/gpio_link_rx.sv
// gpio_link_rx: synchronizes and debounces the two raw link lines, emits rise pulses and a per-frame move latch.
// Optional stuck-line detection is built when the macro GPIO_RX_STUCK_DET_EN is defined.

module gpio_link_rx_chan #(
    parameter int DEBOUNCE_CYCLES = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW:0] LAST = (CW + 1)'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE_LOW, PEND_HIGH, IDLE_HIGH, PEND_LOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW:0]   cnt_inc;
    logic          done;

    // Acceptance is judged on the incremented count, so a stable run of
    // DEBOUNCE_CYCLES synchronized samples commits the new level.
    assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
    assign done    = (cnt_inc >= LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        case (state_q)
            IDLE_LOW: if (s2_q) begin
                state_d = PEND_HIGH;
                cnt_d   = '0;
            end
            PEND_HIGH: begin
                if (!s2_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            IDLE_HIGH: if (!s2_q) begin
                state_d = PEND_LOW;
                cnt_d   = '0;
            end
            PEND_LOW: begin
                if (s2_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
endmodule

module gpio_link_rx #(
    parameter int DEBOUNCE_CYCLES = 400,
    parameter int STUCK_FRAMES    = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gpio_left_in,
    input  logic       gpio_right_in,
    input  logic       v_tick,
    output logic       left_level,
    output logic       right_level,
    output logic       left_rise,
    output logic       right_rise,
    output logic       move_left,
    output logic       move_right,
    output logic [1:0] stuck
);
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("gpio_link_rx: DEBOUNCE_CYCLES out of range");
    end
    if (STUCK_FRAMES < 1 || STUCK_FRAMES > 255) begin : g_bad_stuck
        $error("gpio_link_rx: STUCK_FRAMES out of range");
    end

    // Channel 1 is the left line, channel 0 the right, matching the stuck bit order.
    logic [1:0] raw, level, rise, lvl_eff, stuck_w;
    logic       v_prev_q, frame_edge;
    logic       move_l_q, move_l_d, move_r_q, move_r_d;

    assign raw = {gpio_left_in, gpio_right_in};

    for (genvar c = 0; c < 2; c++) begin : g_chan
        gpio_link_rx_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw[c]),
            .level_o (level[c]),
            .rise_o  (rise[c])
        );
    end

    assign frame_edge = v_tick & ~v_prev_q;

`ifdef GPIO_RX_STUCK_DET_EN
    localparam int FW = $clog2(STUCK_FRAMES + 1);
    localparam logic [FW-1:0] SF_MAX = FW'(STUCK_FRAMES);

    for (genvar c = 0; c < 2; c++) begin : g_stuck
        logic [FW-1:0] fc_q, fc_d;

        always_comb begin
            fc_d = fc_q;
            if (!level[c])
                fc_d = '0;
            else if (frame_edge && fc_q < SF_MAX)
                fc_d = fc_q + FW'(1);
        end

        always_ff @(posedge clk) begin
            if (rst) fc_q <= '0;
            else     fc_q <= fc_d;
        end

        // Gated by level so the flag drops the same cycle the line is released.
        assign stuck_w[c] = level[c] && (fc_q == SF_MAX);
    end

    assign lvl_eff = level & ~stuck_w;
`else
    assign stuck_w = 2'b00;
    assign lvl_eff = level;
`endif

    // Registered levels feed the latch, so a level committed on the frame edge
    // itself is only seen at the following frame.
    always_comb begin
        move_l_d = move_l_q;
        move_r_d = move_r_q;
        if (frame_edge) begin
            move_l_d = lvl_eff[1] & ~lvl_eff[0];
            move_r_d = lvl_eff[0] & ~lvl_eff[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_prev_q <= 1'b1;
            move_l_q <= 1'b0;
            move_r_q <= 1'b0;
        end else begin
            v_prev_q <= v_tick;
            move_l_q <= move_l_d;
            move_r_q <= move_r_d;
        end
    end

    assign left_level  = level[1];
    assign right_level = level[0];
    assign left_rise   = rise[1];
    assign right_rise  = rise[0];
    assign move_left   = move_l_q;
    assign move_right  = move_r_q;
    assign stuck       = stuck_w;
endmodule

// File: tb/tb_gpio_link_rx.sv
// Directed bench for gpio_link_rx with DEBOUNCE_CYCLES=8, STUCK_FRAMES=3, v_tick period 100 cycles.
module tb_gpio_link_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gpio_left_in = 1'b0;
    logic       gpio_right_in = 1'b0;
    logic       v_tick = 1'b0;
    logic       left_level, right_level, left_rise, right_rise;
    logic       move_left, move_right;
    logic [1:0] stuck;

    int nvec = 0;
    int nerr = 0;
    int ph = 50;
    int lrise_cnt = 0, rrise_cnt = 0;
    int rlvl_seen = 0, mr_seen = 0;

    gpio_link_rx #(.DEBOUNCE_CYCLES(8), .STUCK_FRAMES(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_left_in  (gpio_left_in),
        .gpio_right_in (gpio_right_in),
        .v_tick        (v_tick),
        .left_level    (left_level),
        .right_level   (right_level),
        .left_rise     (left_rise),
        .right_rise    (right_rise),
        .move_left     (move_left),
        .move_right    (move_right),
        .stuck         (stuck)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (left_rise)   lrise_cnt <= lrise_cnt + 1;
        if (right_rise)  rrise_cnt <= rrise_cnt + 1;
        if (right_level) rlvl_seen <= rlvl_seen + 1;
        if (move_right)  mr_seen   <= mr_seen + 1;
    end

    // v_tick is high for phases 0..9; a phase of 0 after a step means the
    // next posedge samples the frame edge.
    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph == 99) ? 0 : ph + 1;
        v_tick = (ph < 10);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic to_frame();
        while (ph != 0) step();
        step();
    endtask

    task automatic wait_ph(input int p);
        while (ph != p) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(4);
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic gl, gr;
        logic ll, rl, ml, mr;
        int   lr, rr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{gl:0, gr:0, ll:0, rl:0, ml:0, mr:0, lr:0, rr:0};
        tbl[1] = '{gl:1, gr:0, ll:1, rl:0, ml:1, mr:0, lr:1, rr:0};
        tbl[2] = '{gl:0, gr:1, ll:0, rl:1, ml:0, mr:1, lr:0, rr:1};
        tbl[3] = '{gl:1, gr:1, ll:1, rl:1, ml:0, mr:0, lr:1, rr:1};
        tbl[4] = '{gl:0, gr:0, ll:0, rl:0, ml:0, mr:0, lr:0, rr:0};

        // Reset release with v_tick held high: no spurious frame edge.
        ph = 0; v_tick = 1'b1;
        do_reset();
        chk("rst_left_level",  left_level,  0);
        chk("rst_right_level", right_level, 0);
        chk("rst_rises",       left_rise | right_rise, 0);
        chk("rst_moves",       {move_left, move_right}, 0);
        chk("rst_stuck",       stuck, 0);
        wait_ph(20);
        chk("rst_moves_after_fall", {move_left, move_right}, 0);

        // Steady-state vectors: 120 cycles covers debounce plus one frame edge.
        for (int i = 0; i < 5; i++) begin
            gpio_left_in  = tbl[i].gl;
            gpio_right_in = tbl[i].gr;
            do_reset();
            lrise_cnt = 0; rrise_cnt = 0;
            steps(120);
            chk($sformatf("v%0d_left_level", i),  left_level,  tbl[i].ll);
            chk($sformatf("v%0d_right_level", i), right_level, tbl[i].rl);
            chk($sformatf("v%0d_move_left", i),   move_left,   tbl[i].ml);
            chk($sformatf("v%0d_move_right", i),  move_right,  tbl[i].mr);
            chk($sformatf("v%0d_left_rises", i),  lrise_cnt,   tbl[i].lr);
            chk($sformatf("v%0d_right_rises", i), rrise_cnt,   tbl[i].rr);
            chk($sformatf("v%0d_stuck", i),       stuck,       0);
        end

        // Clean press latency: level is 0 after 9 edges, 1 after 10.
        gpio_left_in = 1'b0; gpio_right_in = 1'b0;
        do_reset();
        wait_ph(20);
        lrise_cnt = 0;
        gpio_left_in = 1'b1;
        steps(9);
        chk("press_level_at_9", left_level, 0);
        step();
        chk("press_level_at_10", left_level, 1);
        chk("press_rise_at_10",  left_rise,  1);
        step();
        chk("press_rise_at_11",  left_rise,  0);
        to_frame();
        chk("press_move_left",  move_left,  1);
        chk("press_move_right", move_right, 0);
        chk("press_rise_count", lrise_cnt,  1);

        // Glitch rejection: 6-cycle pulse on the right line.
        gpio_left_in = 1'b0;
        do_reset();
        steps(2);
        rrise_cnt = 0; rlvl_seen = 0; mr_seen = 0;
        gpio_right_in = 1'b1;
        steps(6);
        gpio_right_in = 1'b0;
        steps(150);
        chk("glitch_level_seen", rlvl_seen, 0);
        chk("glitch_rises",      rrise_cnt, 0);
        chk("glitch_move_seen",  mr_seen,   0);

        // Same-cycle edge: level commits on the posedge that samples the frame edge.
        do_reset();
        wait_ph(91);
        gpio_left_in = 1'b1;
        steps(10);
        chk("same_level",        left_level, 1);
        chk("same_move_left",    move_left,  0);
        wait_ph(0);
        chk("same_move_hold",    move_left,  0);
        step();
        chk("same_move_next",    move_left,  1);

        // Stuck detection: line held across 5 frames, then released.
        gpio_left_in = 1'b0;
        do_reset();
        wait_ph(20);
        gpio_left_in = 1'b1;
        steps(12);
        for (int f = 1; f <= 5; f++) begin
            to_frame();
`ifdef GPIO_RX_STUCK_DET_EN
            chk($sformatf("stuck_f%0d", f), stuck, (f >= 3) ? 2 : 0);
            chk($sformatf("stuck_move_f%0d", f), move_left, (f <= 3) ? 1 : 0);
`else
            chk($sformatf("stuck_f%0d", f), stuck, 0);
            chk($sformatf("stuck_move_f%0d", f), move_left, 1);
`endif
        end
        gpio_left_in = 1'b0;
        steps(9);
        chk("release_level_at_9", left_level, 1);
        step();
        chk("release_level_at_10", left_level, 0);
        chk("release_stuck", stuck, 0);
        to_frame();
        chk("release_move_left", move_left, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
